reg_oper_unit: RTL and testbench

Parametrised successor to the 4-bit register-operations block. It holds a WIDTH-bit register and executes one operation per start request. Supported operations are hold, load, shifts, rotates, increment and decrement. Shifts and rotates move one bit per clock, so a multi-bit shift takes multiple cycles, paced by a busy/done handshake. It sits in the datapath as a general-purpose operand register driven by a controller FSM.

---
 rtl/reg_oper_unit.sv | 187 ++++++++++++++++++
 tb/tb_reg_oper_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_oper_unit.sv
// reg_oper_unit: WIDTH-bit operand register executing one operation per
// start request (hold, load, shl, shr, rotl, rotr, inc, dec).
// Shifts and rotates move one bit per clock, paced by busy/done.
//
// Optional feature macro: REGOP_ARITH_SHIFT_EN
//   defined   -> shr fills with the current MSB (arithmetic shift), sin ignored
//   undefined -> shr fills with sin (logical/serial shift)
//
// Handshake: start_i (with op_i/in_i/amt_i) is accepted on a rising edge only
// while busy_o=0; a start while busy_o=1 is dropped, not queued. done_o is a
// one-cycle pulse in the cycle following completion of the accepted request,
// so a new start may be issued in the same cycle done_o=1.
module reg_oper_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] o_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbg_state_o
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] o_q,     o_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;

  // One-position step for the latched shift/rotate op
  logic [WIDTH-1:0] step_val;
  logic             step_c;
  logic             shr_fill;
  // Arithmetic helpers for inc/dec
  logic [WIDTH:0]   inc_sum;
  logic             start_is_shift;

  // shr fill bit: MSB replication or live serial input
  always_comb begin
`ifdef REGOP_ARITH_SHIFT_EN
    shr_fill = o_q[WIDTH-1];
`else
    shr_fill = sin_i;
`endif
  end

  // Single-position shift/rotate of the register for the latched op
  always_comb begin
    step_val = o_q;
    step_c   = cout_q;
    case (op_q)
      OP_SHL: begin
        step_val = {o_q[WIDTH-2:0], sin_i};
        step_c   = o_q[WIDTH-1];
      end
      OP_SHR: begin
        step_val = {shr_fill, o_q[WIDTH-1:1]};
        step_c   = o_q[0];
      end
      OP_ROTL: begin
        step_val = {o_q[WIDTH-2:0], o_q[WIDTH-1]};
        step_c   = o_q[WIDTH-1];
      end
      OP_ROTR: begin
        step_val = {o_q[0], o_q[WIDTH-1:1]};
        step_c   = o_q[0];
      end
      default: begin
        step_val = o_q;
        step_c   = cout_q;
      end
    endcase
  end

  // Decode of the incoming request and the increment carry chain
  always_comb begin
    start_is_shift = (op_i == OP_SHL) || (op_i == OP_SHR) ||
                     (op_i == OP_ROTL) || (op_i == OP_ROTR);
    inc_sum        = {1'b0, o_q} + {{WIDTH{1'b0}}, 1'b1};
  end

  // Next-state and datapath update; IDLE accepts requests, RUN steps once per edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    o_d     = o_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (start_is_shift && (amt_i != '0)) begin
            // Capture only; the first bit moves on the next edge
            state_d = S_RUN;
            cnt_d   = amt_i;
            op_d    = op_i;
          end else begin
            done_d = 1'b1;
            case (op_i)
              OP_LOAD: begin
                o_d    = in_i;
                cout_d = 1'b0;
              end
              OP_INC: begin
                o_d    = inc_sum[WIDTH-1:0];
                cout_d = inc_sum[WIDTH];
              end
              OP_DEC: begin
                o_d    = o_q - {{(WIDTH-1){1'b0}}, 1'b1};
                cout_d = (o_q == '0);
              end
              default: begin
                // hold, or a shift/rotate with amt=0: value kept, cout cleared
                o_d    = o_q;
                cout_d = 1'b0;
              end
            endcase
          end
        end
      end
      S_RUN: begin
        o_d    = step_val;
        cout_d = step_c;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; synchronous reset aborts any operation without a done pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      o_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Output mapping
  always_comb begin
    o_o         = o_q;
    cout_o      = cout_q;
    busy_o      = (state_q == S_RUN);
    done_o      = done_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_reg_oper_unit.sv
// Directed bench for reg_oper_unit (WIDTH=4, AMT_W=2). Inputs change 1 time
// unit after the rising edge; outputs are checked at that same point.
module tb_reg_oper_unit;

  logic       clk_i;
  logic       reset_i;
  logic       start_i;
  logic [2:0] op_i;
  logic [3:0] in_i;
  logic [1:0] amt_i;
  logic       sin_i;
  logic [3:0] o_o;
  logic       cout_o;
  logic       busy_o;
  logic       done_o;
  logic       dbg_state_o;

  int total;
  int bad;

  reg_oper_unit #(.WIDTH(4), .AMT_W(2)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .in_i        (in_i),
    .amt_i       (amt_i),
    .sin_i       (sin_i),
    .o_o         (o_o),
    .cout_o      (cout_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] din, input logic [1:0] amt, input logic sin);
    start_i = 1'b1;
    op_i    = op;
    in_i    = din;
    amt_i   = amt;
    sin_i   = sin;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_i = 1'b1;
    start_i = 1'b0;
    op_i    = 3'b000;
    in_i    = 4'h0;
    amt_i   = 2'd0;
    sin_i   = 1'b0;
    tick();
    tick();
    chk("rst_o", 32'(o_o), 32'h0);
    chk("rst_cout", 32'(cout_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_state", 32'(dbg_state_o), 32'h0);
    reset_i = 1'b0;
    tick();

    // load 1010
    issue(3'b001, 4'b1010, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    chk("load_o", 32'(o_o), 32'hA);
    chk("load_done", 32'(done_o), 32'h1);
    chk("load_busy", 32'(busy_o), 32'h0);
    chk("load_cout", 32'(cout_o), 32'h0);
    tick();
    chk("load_done_clr", 32'(done_o), 32'h0);

    // shl by 2 with sin=1: 1010 -> 0101 -> 1011
    issue(3'b010, 4'h0, 2'd2, 1'b1);
    tick();
    start_i = 1'b0;
    chk("shl_cap_o", 32'(o_o), 32'hA);
    chk("shl_cap_busy", 32'(busy_o), 32'h1);
    chk("shl_cap_done", 32'(done_o), 32'h0);
    tick();
    chk("shl_s1_o", 32'(o_o), 32'h5);
    chk("shl_s1_cout", 32'(cout_o), 32'h1);
    chk("shl_s1_busy", 32'(busy_o), 32'h1);
    tick();
    chk("shl_s2_o", 32'(o_o), 32'hB);
    chk("shl_s2_cout", 32'(cout_o), 32'h0);
    chk("shl_s2_busy", 32'(busy_o), 32'h0);
    chk("shl_s2_done", 32'(done_o), 32'h1);
    sin_i = 1'b0;
    tick();
    chk("shl_done_clr", 32'(done_o), 32'h0);

    // rotr by 3 on 0110, with a load 1111 attempted while busy
    issue(3'b001, 4'b0110, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    issue(3'b101, 4'h0, 2'd3, 1'b0);
    tick();
    chk("rotr_cap_busy", 32'(busy_o), 32'h1);
    issue(3'b001, 4'b1111, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    chk("rotr_s1_o", 32'(o_o), 32'h3);
    chk("rotr_s1_cout", 32'(cout_o), 32'h0);
    tick();
    chk("rotr_s2_o", 32'(o_o), 32'h9);
    chk("rotr_s2_cout", 32'(cout_o), 32'h1);
    chk("rotr_s2_done", 32'(done_o), 32'h0);
    tick();
    chk("rotr_s3_o", 32'(o_o), 32'hC);
    chk("rotr_s3_cout", 32'(cout_o), 32'h1);
    chk("rotr_s3_busy", 32'(busy_o), 32'h0);
    chk("rotr_s3_done", 32'(done_o), 32'h1);
    tick();
    chk("rotr_done_clr", 32'(done_o), 32'h0);
    chk("busy_load_ignored", 32'(o_o), 32'hC);

    // back-to-back: load 1111, inc (wrap), dec (wrap), then load 0100, inc
    issue(3'b001, 4'b1111, 2'd0, 1'b0);
    tick();
    issue(3'b110, 4'h0, 2'd0, 1'b0);
    tick();
    chk("inc_wrap_o", 32'(o_o), 32'h0);
    chk("inc_wrap_cout", 32'(cout_o), 32'h1);
    chk("inc_wrap_done", 32'(done_o), 32'h1);
    issue(3'b111, 4'h0, 2'd0, 1'b0);
    tick();
    chk("dec_wrap_o", 32'(o_o), 32'hF);
    chk("dec_wrap_cout", 32'(cout_o), 32'h1);
    chk("dec_wrap_done", 32'(done_o), 32'h1);
    issue(3'b001, 4'b0100, 2'd0, 1'b0);
    tick();
    chk("load4_cout", 32'(cout_o), 32'h0);
    issue(3'b110, 4'h0, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    chk("inc_o", 32'(o_o), 32'h5);
    chk("inc_cout", 32'(cout_o), 32'h0);
    tick();

    // dec 0101 -> 0100 without borrow
    issue(3'b111, 4'h0, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    chk("dec_o", 32'(o_o), 32'h4);
    chk("dec_cout", 32'(cout_o), 32'h0);
    tick();

    // amt=0 rotate clears cout, keeps value, single-cycle
    issue(3'b001, 4'b0000, 2'd0, 1'b0);
    tick();
    issue(3'b111, 4'h0, 2'd0, 1'b0);
    tick();
    chk("dec0_cout", 32'(cout_o), 32'h1);
    issue(3'b100, 4'h0, 2'd0, 1'b0);
    tick();
    start_i = 1'b0;
    chk("amt0_o", 32'(o_o), 32'hF);
    chk("amt0_cout", 32'(cout_o), 32'h0);
    chk("amt0_busy", 32'(busy_o), 32'h0);
    chk("amt0_done", 32'(done_o), 32'h1);
    tick();

    // reset at the second shift edge of rotl by 3 on 0110
    issue(3'b001, 4'b0110, 2'd0, 1'b0);
    tick();
    issue(3'b100, 4'h0, 2'd3, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    chk("rotl_s1_o", 32'(o_o), 32'hC);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrst_o", 32'(o_o), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_done", 32'(done_o), 32'h0);
    chk("midrst_state", 32'(dbg_state_o), 32'h0);
    tick();
    chk("midrst_done_after", 32'(done_o), 32'h0);
    chk("midrst_o_after", 32'(o_o), 32'h0);

    // shr by 1 on 1010 with sin=0
    issue(3'b001, 4'b1010, 2'd0, 1'b0);
    tick();
    issue(3'b011, 4'h0, 2'd1, 1'b0);
    tick();
    start_i = 1'b0;
    chk("shr_cap_busy", 32'(busy_o), 32'h1);
    tick();
`ifdef REGOP_ARITH_SHIFT_EN
    chk("shr_o", 32'(o_o), 32'hD);
`else
    chk("shr_o", 32'(o_o), 32'h5);
`endif
    chk("shr_cout", 32'(cout_o), 32'h0);
    chk("shr_done", 32'(done_o), 32'h1);
    tick();

    // shr by 1 on 0101 with sin=1
    issue(3'b001, 4'b0101, 2'd0, 1'b0);
    tick();
    issue(3'b011, 4'h0, 2'd1, 1'b1);
    tick();
    start_i = 1'b0;
    tick();
`ifdef REGOP_ARITH_SHIFT_EN
    chk("shr_sin_o", 32'(o_o), 32'h2);
`else
    chk("shr_sin_o", 32'(o_o), 32'hA);
`endif
    chk("shr_sin_cout", 32'(cout_o), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
